// File: rtl/mmram_match_ctrl.sv
// MMRAM matching controller: hashes tokens into a tag/occupancy table (linear probing)
// and drives the stage's ADDR/WR_E/DEL. Define MMCTRL_STATS_EN to add fire/store counters.
module mmram_match_ctrl #(
  parameter int ADDR_W    = 6,
  parameter int TAG_W     = 12,
  parameter int MAX_PROBE = 4
) (
  input  logic              CP,
  input  logic              MR,
  input  logic              TOK_VALID,
  output logic              TOK_ACK,
  input  logic              TOK_MF,
  input  logic              TOK_LR,
  input  logic [TAG_W-1:0]  TOK_TAG,
  output logic              STG_SEND,
  input  logic              STG_ACK,
  output logic [ADDR_W-1:0] ADDR,
  output logic              WR_E,
  output logic              DEL,
  output logic [ADDR_W:0]   OCC_CNT,
  output logic              OVF,
  output logic [15:0]       HIT_CNT,
  output logic [15:0]       STORE_CNT
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam int PW    = ADDR_W + 1;  // probe counter must hold MAX_PROBE-1 up to DEPTH-1
  localparam int CW    = ADDR_W + 1;

  typedef enum logic [1:0] {IDLE, LOOKUP, ISSUE} state_t;
  typedef enum logic [1:0] {OP_PASS, OP_FIRE, OP_STORE, OP_DROP} op_t;

  state_t state, state_nxt;
  op_t    op, dec_op;
  logic   dec;
  logic [ADDR_W-1:0] dec_addr;

  logic              lat_lr;
  logic [TAG_W-1:0]  lat_tag;
  logic [PW-1:0]     probe;
  logic              fe_vld;
  logic [ADDR_W-1:0] fe_addr;

  logic              tbl_vld [DEPTH];
  logic              tbl_lr  [DEPTH];
  logic [TAG_W-1:0]  tbl_tag [DEPTH];

  logic [ADDR_W-1:0] hash, probe_addr;
  logic              last_probe, hit, commit;

  assign hash       = lat_tag[ADDR_W-1:0] ^ lat_tag[TAG_W-1:TAG_W-ADDR_W];
  assign probe_addr = hash + probe[ADDR_W-1:0];
  assign last_probe = (probe == PW'(MAX_PROBE - 1));
  assign hit        = tbl_vld[probe_addr] && (tbl_tag[probe_addr] == lat_tag) &&
                      (tbl_lr[probe_addr] != lat_lr);
  assign commit     = (state == ISSUE) && STG_ACK;

  always_ff @(posedge CP) begin
    if (MR) state <= IDLE;
    else    state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    TOK_ACK   = 1'b0;
    STG_SEND  = 1'b0;
    dec       = 1'b0;
    dec_op    = OP_PASS;
    dec_addr  = '0;
    case (state)
      IDLE: begin
        if (TOK_VALID) begin
          TOK_ACK = 1'b1;
          if (!TOK_MF) begin
            dec       = 1'b1;
            state_nxt = ISSUE;
          end else begin
            state_nxt = LOOKUP;
          end
        end
      end
      LOOKUP: begin
        if (hit) begin
          dec       = 1'b1;
          dec_op    = OP_FIRE;
          dec_addr  = probe_addr;
          state_nxt = ISSUE;
        end else if (last_probe) begin
          dec       = 1'b1;
          state_nxt = ISSUE;
          if (fe_vld) begin
            dec_op   = OP_STORE;
            dec_addr = fe_addr;
          end else if (!tbl_vld[probe_addr]) begin
            dec_op   = OP_STORE;
            dec_addr = probe_addr;
          end else begin
            dec_op   = OP_DROP;
            dec_addr = hash;
          end
        end
      end
      ISSUE: begin
        STG_SEND = 1'b1;
        if (STG_ACK) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CP) begin
    if (MR) begin
      lat_lr  <= 1'b0;
      lat_tag <= '0;
      probe   <= '0;
      fe_vld  <= 1'b0;
      fe_addr <= '0;
      op      <= OP_PASS;
      ADDR    <= '0;
      WR_E    <= 1'b0;
      DEL     <= 1'b0;
      OVF     <= 1'b0;
      OCC_CNT <= '0;
    end else begin
      if (state == IDLE && TOK_VALID) begin
        lat_lr  <= TOK_LR;
        lat_tag <= TOK_TAG;
        probe   <= '0;
        fe_vld  <= 1'b0;
      end
      if (state == LOOKUP) begin
        probe <= probe + PW'(1);
        if (!tbl_vld[probe_addr] && !fe_vld) begin
          fe_vld  <= 1'b1;
          fe_addr <= probe_addr;
        end
      end
      if (dec) begin
        op   <= dec_op;
        ADDR <= dec_addr;
        WR_E <= (dec_op == OP_STORE);
        DEL  <= (dec_op == OP_STORE) || (dec_op == OP_DROP);
        if (dec_op == OP_DROP) OVF <= 1'b1;
      end
      if (commit) begin
        WR_E <= 1'b0;
        DEL  <= 1'b0;
        if (op == OP_FIRE)  OCC_CNT <= OCC_CNT - CW'(1);
        if (op == OP_STORE) OCC_CNT <= OCC_CNT + CW'(1);
      end
    end
  end

  always_ff @(posedge CP) begin
    if (MR) begin
      for (int i = 0; i < DEPTH; i++) tbl_vld[i] <= 1'b0;
    end else if (commit && op == OP_FIRE) begin
      tbl_vld[ADDR] <= 1'b0;
    end else if (commit && op == OP_STORE) begin
      tbl_vld[ADDR] <= 1'b1;
    end
  end

  // NOTE: payload is only meaningful where tbl_vld is set, so it is left unreset like plain RAM.
  always_ff @(posedge CP) begin
    if (commit && op == OP_STORE) begin
      tbl_lr[ADDR]  <= lat_lr;
      tbl_tag[ADDR] <= lat_tag;
    end
  end

`ifdef MMCTRL_STATS_EN
  always_ff @(posedge CP) begin
    if (MR) begin
      HIT_CNT   <= '0;
      STORE_CNT <= '0;
    end else if (commit) begin
      if (op == OP_FIRE && HIT_CNT != 16'hFFFF)    HIT_CNT   <= HIT_CNT + 16'd1;
      if (op == OP_STORE && STORE_CNT != 16'hFFFF) STORE_CNT <= STORE_CNT + 16'd1;
    end
  end
`else
  assign HIT_CNT   = '0;
  assign STORE_CNT = '0;
`endif

endmodule

// File: tb/tb_mmram_match_ctrl.sv
// Self-checking bench for mmram_match_ctrl: directed vector table, reset corner cases,
// and random tokens checked against a probing-table reference model.
module tb_mmram_match_ctrl;
  localparam int ADDR_W = 6, TAG_W = 12, MAX_PROBE = 4, DEPTH = 64;
  localparam int K_PASS = 0, K_FIRE = 1, K_STORE = 2, K_DROP = 3;

  logic        CP = 1'b0;
  logic        MR = 1'b1, TOK_VALID = 1'b0, TOK_MF = 1'b0, TOK_LR = 1'b0, STG_ACK = 1'b0;
  logic [11:0] TOK_TAG = '0;
  logic        TOK_ACK, STG_SEND, WR_E, DEL, OVF;
  logic [5:0]  ADDR;
  logic [6:0]  OCC_CNT;
  logic [15:0] HIT_CNT, STORE_CNT;

  int errors = 0;
  int checks = 0;

  typedef struct { int kind; int lat; int addr; int occ; logic ovf; } exp_t;
  typedef struct { logic mf; logic lr; logic [11:0] tag; int stall; exp_t e; } vec_t;

  logic        m_vld [DEPTH];
  logic        m_lr  [DEPTH];
  logic [11:0] m_tag [DEPTH];
  int          m_occ, m_hit, m_store;
  logic        m_ovf;

  mmram_match_ctrl #(.ADDR_W(ADDR_W), .TAG_W(TAG_W), .MAX_PROBE(MAX_PROBE)) dut (
    .CP(CP), .MR(MR), .TOK_VALID(TOK_VALID), .TOK_ACK(TOK_ACK), .TOK_MF(TOK_MF),
    .TOK_LR(TOK_LR), .TOK_TAG(TOK_TAG), .STG_SEND(STG_SEND), .STG_ACK(STG_ACK),
    .ADDR(ADDR), .WR_E(WR_E), .DEL(DEL), .OCC_CNT(OCC_CNT), .OVF(OVF),
    .HIT_CNT(HIT_CNT), .STORE_CNT(STORE_CNT)
  );

  always #5 CP = ~CP;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_vld[i] = 1'b0;
    m_occ = 0; m_hit = 0; m_store = 0; m_ovf = 1'b0;
  endtask

  // Outcome of one token from the matching rules: probe the hash window in order.
  function automatic exp_t predict(input logic mf, input logic lr, input logic [11:0] tag);
    exp_t e;
    int h, fe, a;
    e.kind = K_PASS; e.lat = 1; e.addr = 0; e.occ = m_occ; e.ovf = m_ovf;
    if (!mf) return e;
    h  = int'(tag[5:0] ^ tag[11:6]);
    fe = -1;
    for (int k = 0; k < MAX_PROBE; k++) begin
      a = (h + k) % DEPTH;
      if (m_vld[a] && m_tag[a] == tag && m_lr[a] != lr) begin
        e.kind = K_FIRE; e.lat = 2 + k; e.addr = a; e.occ = m_occ - 1;
        return e;
      end
      if (!m_vld[a] && fe < 0) fe = a;
    end
    e.lat = 1 + MAX_PROBE;
    if (fe >= 0) begin
      e.kind = K_STORE; e.addr = fe; e.occ = m_occ + 1;
    end else begin
      e.kind = K_DROP; e.addr = h; e.ovf = 1'b1;
    end
    return e;
  endfunction

  task automatic model_commit(input logic lr, input logic [11:0] tag, input exp_t e);
    if (e.kind == K_FIRE) begin
      m_vld[e.addr] = 1'b0; m_hit++;
    end else if (e.kind == K_STORE) begin
      m_vld[e.addr] = 1'b1; m_lr[e.addr] = lr; m_tag[e.addr] = tag; m_store++;
    end
    m_occ = e.occ; m_ovf = e.ovf;
  endtask

  task automatic check_stats(input string nm);
`ifdef MMCTRL_STATS_EN
    check({nm, " hit_cnt"}, HIT_CNT, m_hit);
    check({nm, " store_cnt"}, STORE_CNT, m_store);
`else
    check({nm, " hit_cnt"}, HIT_CNT, 0);
    check({nm, " store_cnt"}, STORE_CNT, 0);
`endif
  endtask

  // Called just after a negedge with the DUT idle; returns just after a negedge, idle again.
  task automatic send_token(input logic mf, input logic lr, input logic [11:0] tag,
                            input int stall, input exp_t e, input string nm);
    logic wr, dl;
    int   occ0;
    wr   = (e.kind == K_STORE);
    dl   = (e.kind == K_STORE) || (e.kind == K_DROP);
    occ0 = m_occ;
    TOK_VALID = 1'b1; TOK_MF = mf; TOK_LR = lr; TOK_TAG = tag; STG_ACK = 1'b0;
    #1 check({nm, " tok_ack"}, TOK_ACK, 1);
    for (int c = 1; c <= e.lat; c++) begin
      @(negedge CP);
      if (c < e.lat) begin
        check($sformatf("%s early_send c%0d", nm, c), STG_SEND, 0);
        check($sformatf("%s busy_ack c%0d", nm, c), TOK_ACK, 0);
      end else begin
        check({nm, " stg_send"}, STG_SEND, 1);
        check({nm, " addr"}, ADDR, e.addr);
        check({nm, " wr_e"}, WR_E, wr);
        check({nm, " del"}, DEL, dl);
        check({nm, " ovf"}, OVF, e.ovf);
        check({nm, " occ_pre"}, OCC_CNT, occ0);
      end
      if (stall == 0) TOK_VALID = 1'b0;
    end
    for (int s = 0; s < stall; s++) begin
      @(negedge CP);
      check($sformatf("%s stall%0d send", nm, s), STG_SEND, 1);
      check($sformatf("%s stall%0d hold", nm, s), {ADDR, WR_E, DEL}, {e.addr[5:0], wr, dl});
      check($sformatf("%s stall%0d tok_ack", nm, s), TOK_ACK, 0);
      check($sformatf("%s stall%0d occ", nm, s), OCC_CNT, occ0);
    end
    STG_ACK = 1'b1; TOK_VALID = 1'b0;
    @(negedge CP);
    STG_ACK = 1'b0;
    model_commit(lr, tag, e);
    check({nm, " send_off"}, {STG_SEND, WR_E, DEL}, 3'b000);
    check({nm, " occ"}, OCC_CNT, m_occ);
    check({nm, " ovf_post"}, OVF, m_ovf);
    check_stats(nm);
  endtask

  task automatic do_reset();
    @(negedge CP);
    MR = 1'b1; TOK_VALID = 1'b0; TOK_MF = 1'b0; TOK_LR = 1'b0; TOK_TAG = '0; STG_ACK = 1'b0;
    @(negedge CP);
    MR = 1'b0;
    model_reset();
  endtask

  function automatic vec_t mk(input logic mf, input logic lr, input logic [11:0] tag,
                              input int stall, input int kind, input int lat, input int addr,
                              input int occ, input logic ovf);
    vec_t v;
    v.mf = mf; v.lr = lr; v.tag = tag; v.stall = stall;
    v.e.kind = kind; v.e.lat = lat; v.e.addr = addr; v.e.occ = occ; v.e.ovf = ovf;
    return v;
  endfunction

  vec_t vecs[20];

  initial begin
    exp_t        e;
    logic        mf, lr;
    logic [11:0] tag;
    int          st;

    // Hand-derived sequence from an empty table (hash = tag[5:0] ^ tag[11:6]).
    vecs[0]  = mk(0, 0, 12'h123, 0, K_PASS,  1, 0,  0, 0);
    vecs[1]  = mk(1, 0, 12'h041, 0, K_STORE, 5, 0,  1, 0);
    vecs[2]  = mk(1, 1, 12'h041, 0, K_FIRE,  2, 0,  0, 0);
    vecs[3]  = mk(1, 0, 12'h041, 0, K_STORE, 5, 0,  1, 0);
    vecs[4]  = mk(1, 0, 12'h000, 0, K_STORE, 5, 1,  2, 0);
    vecs[5]  = mk(1, 1, 12'h000, 0, K_FIRE,  3, 1,  1, 0);
    vecs[6]  = mk(1, 1, 12'h041, 0, K_FIRE,  2, 0,  0, 0);
    vecs[7]  = mk(1, 0, 12'h000, 0, K_STORE, 5, 0,  1, 0);
    vecs[8]  = mk(1, 0, 12'h041, 0, K_STORE, 5, 1,  2, 0);
    vecs[9]  = mk(1, 0, 12'h082, 0, K_STORE, 5, 2,  3, 0);
    vecs[10] = mk(1, 0, 12'h0C3, 5, K_STORE, 5, 3,  4, 0);
    vecs[11] = mk(1, 0, 12'h104, 0, K_DROP,  5, 0,  4, 1);
    vecs[12] = mk(1, 0, 12'h03F, 0, K_STORE, 5, 63, 5, 1);
    vecs[13] = mk(1, 1, 12'h000, 0, K_FIRE,  2, 0,  4, 1);
    vecs[14] = mk(1, 0, 12'hFC0, 0, K_STORE, 5, 0,  5, 1);
    vecs[15] = mk(1, 1, 12'hFC0, 0, K_FIRE,  3, 0,  4, 1);
    vecs[16] = mk(1, 0, 12'h041, 0, K_STORE, 5, 0,  5, 1);
    vecs[17] = mk(1, 1, 12'h041, 0, K_FIRE,  2, 0,  4, 1);
    vecs[18] = mk(0, 1, 12'hABC, 2, K_PASS,  1, 0,  4, 1);
    vecs[19] = mk(1, 1, 12'h082, 0, K_FIRE,  4, 2,  3, 1);

    do_reset();
    check("rst tok_ack", TOK_ACK, 0);
    check("rst stg_send", STG_SEND, 0);
    check("rst addr", ADDR, 0);
    check("rst wr_del", {WR_E, DEL}, 2'b00);
    check("rst occ", OCC_CNT, 0);
    check("rst ovf", OVF, 0);
    check_stats("rst");

    for (int i = 0; i < 20; i++)
      send_token(vecs[i].mf, vecs[i].lr, vecs[i].tag, vecs[i].stall, vecs[i].e,
                 $sformatf("v%0d", i));

    // Reset during LOOKUP with a populated table and OVF set.
    check("mrl pre occ", OCC_CNT, 3);
    check("mrl pre ovf", OVF, 1);
    TOK_VALID = 1'b1; TOK_MF = 1'b1; TOK_LR = 1'b1; TOK_TAG = 12'h0C3;
    #1 check("mrl tok_ack", TOK_ACK, 1);
    @(negedge CP); TOK_VALID = 1'b0;
    @(negedge CP); MR = 1'b1;
    @(negedge CP); MR = 1'b0;
    model_reset();
    check("mrl stg_send", STG_SEND, 0);
    check("mrl occ", OCC_CNT, 0);
    check("mrl ovf", OVF, 0);
    check("mrl wr_del", {WR_E, DEL}, 2'b00);
    check_stats("mrl");
    e = predict(1, 1, 12'h0C3);
    send_token(1, 1, 12'h0C3, 0, e, "mrl after");
    e = predict(1, 0, 12'h000);
    send_token(1, 0, 12'h000, 0, e, "mri fill");

    // Reset coinciding with the STG_ACK of a fire: the pending commit is lost.
    e = predict(1, 1, 12'h000);
    TOK_VALID = 1'b1; TOK_MF = 1'b1; TOK_LR = 1'b1; TOK_TAG = 12'h000;
    #1 check("mri tok_ack", TOK_ACK, 1);
    for (int c = 1; c <= e.lat; c++) begin
      @(negedge CP);
      TOK_VALID = 1'b0;
    end
    check("mri send", STG_SEND, 1);
    check("mri addr", ADDR, e.addr);
    STG_ACK = 1'b1; MR = 1'b1;
    @(negedge CP);
    STG_ACK = 1'b0; MR = 1'b0;
    model_reset();
    check("mri occ", OCC_CNT, 0);
    check("mri stg_send", STG_SEND, 0);
    check_stats("mri");
    e = predict(1, 1, 12'h000);
    send_token(1, 1, 12'h000, 0, e, "mri after");

    // Random tokens over a small tag pool so hits, collisions and overflows all occur.
    for (int n = 0; n < 300; n++) begin
      if (n % 100 == 0) do_reset();
      mf  = ($urandom_range(0, 7) != 0);
      lr  = 1'($urandom_range(0, 1));
      tag = {6'($urandom_range(0, 3)), 6'($urandom_range(0, 3))};
      st  = $urandom_range(0, 2);
      e   = predict(mf, lr, tag);
      send_token(mf, lr, tag, st, e, $sformatf("rnd%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
